// File: rtl/lsu_bus_master.sv
// lsu_bus_master: converts core load/store accesses into word-aligned req/ack bus transactions
module lsu_bus_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] INSTR_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = 32'h0000_2000,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_we,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_fault,
  output logic [1:0]            lsu_fault_cause,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_BYTES-1:0] mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int OW = $clog2(DATA_BYTES);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] REGION = ADDR_WIDTH'(4096);
  localparam logic [ADDR_WIDTH-1:0] IO_SPAN = ADDR_WIDTH'(12);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, d_cnt;
  logic [OW-1:0] off_q, d_off, off;
  logic [1:0] size_q, d_size, d_cause;
  logic uns_q, d_uns, d_req, d_we, d_done, d_fault;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_BYTES-1:0] d_be;
  logic [DATA_WIDTH-1:0] d_wdata, d_rdata, sh, ext;
  logic misal, in_instr, in_ram, in_io;
  assign lsu_ready = state == IDLE;
  assign off = lsu_addr[OW-1:0];
  assign misal = lsu_size == 2'd3 || (lsu_size == 2'd1 && lsu_addr[0]) || (lsu_size == 2'd2 && off != '0);
  assign in_instr = lsu_addr - INSTR_BASE < REGION;
  assign in_ram = lsu_addr - RAM_BASE < REGION;
  assign in_io = lsu_addr - IO_BASE < IO_SPAN;
  // align the addressed lane to bit 0, then trim and extend to the access size
  always_comb begin
    sh = mem_rdata >> {off_q, 3'b000};
    ext = size_q == 2'd0 ? {{(DATA_WIDTH-8){~uns_q & sh[7]}}, sh[7:0]} :
          size_q == 2'd1 ? {{(DATA_WIDTH-16){~uns_q & sh[15]}}, sh[15:0]} : sh;
  end
  // next state and next values of every registered output
  always_comb begin
    nxt = state;
    d_cnt = cnt;
    d_off = off_q;
    d_size = size_q;
    d_uns = uns_q;
    d_req = mem_req;
    d_we = mem_we;
    d_addr = mem_addr;
    d_be = mem_be;
    d_wdata = mem_wdata;
    d_rdata = lsu_rdata;
    d_done = 1'b0;
    d_fault = 1'b0;
    d_cause = 2'd0;
    if (state == IDLE && lsu_valid) begin
      if (misal || !(in_instr || in_ram || in_io) || (lsu_we && in_instr)) begin
        nxt = RESP;
        d_done = 1'b1;
        d_fault = 1'b1;
        d_cause = misal ? 2'd1 : 2'd2;
      end else begin
        nxt = BUS;
        d_req = 1'b1;
        d_we = lsu_we;
        d_addr = {lsu_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        d_be = lsu_size == 2'd0 ? DATA_BYTES'(1) << off : lsu_size == 2'd1 ? DATA_BYTES'(3) << off : '1;
        d_wdata = lsu_size == 2'd0 ? {DATA_BYTES{lsu_wdata[7:0]}} :
                  lsu_size == 2'd1 ? {(DATA_BYTES/2){lsu_wdata[15:0]}} : lsu_wdata;
        d_cnt = '0;
        d_off = off;
        d_size = lsu_size;
        d_uns = lsu_unsigned;
      end
    end else if (state == BUS) begin
      if (mem_ack) begin
        nxt = RESP;
        d_req = 1'b0;
        d_done = 1'b1;
        d_rdata = mem_we ? '0 : ext;
      end else if (cnt == CNT_LAST) begin
        nxt = RESP;
        d_req = 1'b0;
        d_done = 1'b1;
        d_fault = 1'b1;
        d_cause = 2'd3;
      end else begin
        d_cnt = cnt + 1'b1;
      end
    end else if (state == RESP) begin
      nxt = IDLE;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // registered outputs and captured access attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      off_q <= '0;
      size_q <= 2'd0;
      uns_q <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      lsu_rdata <= '0;
      lsu_done <= 1'b0;
      lsu_fault <= 1'b0;
      lsu_fault_cause <= 2'd0;
    end else begin
      cnt <= d_cnt;
      off_q <= d_off;
      size_q <= d_size;
      uns_q <= d_uns;
      mem_req <= d_req;
      mem_we <= d_we;
      mem_addr <= d_addr;
      mem_be <= d_be;
      mem_wdata <= d_wdata;
      lsu_rdata <= d_rdata;
      lsu_done <= d_done;
      lsu_fault <= d_fault;
      lsu_fault_cause <= d_cause;
    end
  end
endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator between the core's execute stage and the memory-system bus.
- Converts one byte, halfword or word access into a word-aligned bus transaction with byte enables.
- Checks alignment and the system address map; runs a req/ack handshake with a timeout; returns sign- or zero-extended load data.
- One access in flight; the core stalls on lsu_ready.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, bus data width; DATA_BYTES = DATA_WIDTH/8.
- INSTR_BASE, 32'h0000_0000, instruction region base; region size 4096 bytes; read-only for this block.
- RAM_BASE, 32'h0000_1000, scratch RAM base; size 4096 bytes.
- IO_BASE, 32'h0000_2000, switch register; LED at IO_BASE+4; SSEG at IO_BASE+8; mapped space ends at IO_BASE+12, exclusive.
- TIMEOUT_CYCLES, 16, maximum cycles in BUS without mem_ack.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- lsu_valid  in  1  access request from core.
- lsu_ready  out  1  high only in IDLE; access accepted when valid&&ready.
- lsu_we  in  1  1=store, 0=load.
- lsu_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
- lsu_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- lsu_addr  in  ADDR_WIDTH  byte address.
- lsu_wdata  in  DATA_WIDTH  store data, right-justified.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rdata  out  DATA_WIDTH  extended load data; valid with lsu_done.
- lsu_fault  out  1  with lsu_done: access did not complete.
- lsu_fault_cause  out  2  0=none, 1=misaligned/illegal size, 2=unmapped or store to instruction region, 3=timeout.
- mem_req  out  1  bus request; held until mem_ack or timeout.
- mem_we  out  1  bus write strobe.
- mem_addr  out  ADDR_WIDTH  word address; low 2 bits always 0.
- mem_be  out  DATA_BYTES  byte-lane enables.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_ack  in  1  responder completion.
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack.

Behaviour:
- Reset values: state IDLE; lsu_ready=1; lsu_done=0; lsu_fault=0; lsu_fault_cause=0; lsu_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0; timeout counter=0.
- All outputs are registered except lsu_ready, which is decoded from state.
- States: IDLE, BUS, RESP.
- IDLE, on valid&&ready, check in this priority order:
  - Misaligned or illegal: size=3, or half with addr[0]=1, or word with addr[1:0]!=0 -> RESP, fault cause 1.
  - Unmapped: address outside [INSTR_BASE, IO_BASE+12) -> cause 2.
  - Store to instruction region -> cause 2.
  - Faulting accesses never assert mem_req.
  - Otherwise -> BUS and register the bus signals:
    - mem_addr = {addr[31:2], 2'b00}.
    - mem_be: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
    - mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
    - mem_we = lsu_we; counter cleared.
- BUS:
  - mem_req=1, and all mem_* outputs stable until exit.
  - Counter increments each cycle without ack.
  - On mem_ack -> RESP and capture rdata. For loads, shift right by 8*addr[1:0], mask to size, then sign- or zero-extend. Stores return lsu_rdata=0.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack -> RESP with cause 3.
  - If mem_ack arrives in the timeout cycle, ack wins: no fault.
  - mem_req deasserts on the cycle after ack or timeout.
- RESP: lsu_done=1 for exactly one cycle, with lsu_fault and lsu_fault_cause; then -> IDLE.
- Outside RESP: lsu_done=0, lsu_fault=0, lsu_fault_cause=0. lsu_rdata holds its last value.
- Latency:
  - Accept at edge N; mem_req high from N+1.
  - Ack sampled at edge M; lsu_done high at M+1.
  - Zero-wait bus: done 2 cycles after accept.
  - Fault path: done 1 cycle after accept.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after RESP, so the minimum spacing is 3 cycles.
- mem_ack while not in BUS is ignored.
- lsu_valid while not ready is ignored; the core must hold its request.
- Reset mid-transaction: immediate return to reset values. No done pulse for the aborted access. The responder must tolerate mem_req dropping.

Test Plan:
- Word load at 0x1004; mem_ack one cycle later with rdata 0xDEADBEEF -> mem_addr 0x1004, be 4'b1111, done 2 cycles after accept, rdata 0xDEADBEEF, fault 0.
- Byte load at 0x1003, signed, rdata 0x80xxxxxx -> be 4'b1000, rdata 0xFFFFFF80. Repeat unsigned -> 0x00000080. Half load at 0x1002, signed, rdata 0x8001xxxx -> 0xFFFF8001.
- Half store 0xABCD at 0x2006 -> mem_addr 0x2004, be 4'b1100, wdata 0xABCDABCD, we 1.
- Word load at 0x1002 -> fault cause 1, no mem_req, done next cycle. Store to 0x0010 -> cause 2. Load at 0x200C -> cause 2.
- No ack with TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then fault cause 3. Ack on the 16th cycle -> no fault.
- Assert rst in the 3rd BUS cycle -> mem_req=0 and ready=1 immediately; no lsu_done; a subsequent word load at 0x2000 completes normally.
